j_pulse_gen: RTL and testbench

- Parametrised multi-channel successor to the single-channel JERRY pulse/timer divider.
- Each channel is a two-stage down-counter: a prescaler feeding a divider. It emits a one-`sys_clk` pulse once per programmed period.
- Adds over the single-channel block:
  - a channel count parameter;
  - wider counter widths;
  - one-shot vs periodic mode;
  - per-channel load strobe;
  - live count readback.
- Sits beside the DAC/timer logic and drives interrupt and sample-request lines.

---
 rtl/j_pulse_gen_if.sv | 41 ++++
 rtl/j_pulse_gen.sv | 122 ++++++++++++
 tb/tb_j_pulse_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/j_pulse_gen_if.sv
// j_pulse_gen_if -- control/status bundle for the multi-channel pulse generator.
//   ce       count enable tick (shared by all channels)
//   load     per-channel load strobe
//   pre/div  shared reload buses, sampled on load
//   oneshot  mode bit for the loaded channel(s), sampled on load
//   stop     per-channel freeze
//   casc     per-channel cascade select, sampled on load (J_PULSE_CASCADE_EN only)
//   pulse    one-cycle pulse per channel period
//   busy     channel is in RUN
//   cnt      divider count per channel, channel n at [n*DW +: DW]
// Modports: master drives the controls; slave is the pulse generator.
interface j_pulse_gen_if #(
  parameter int unsigned CH = 2,
  parameter int unsigned PW = 8,
  parameter int unsigned DW = 16
) ();
  logic             ce;
  logic [CH-1:0]    load;
  logic [PW-1:0]    pre;
  logic [DW-1:0]    div;
  logic             oneshot;
  logic [CH-1:0]    stop;
`ifdef J_PULSE_CASCADE_EN
  logic [CH-1:0]    casc;
`endif
  logic [CH-1:0]    pulse;
  logic [CH-1:0]    busy;
  logic [CH*DW-1:0] cnt;

`ifdef J_PULSE_CASCADE_EN
  modport master (output ce, load, pre, div, oneshot, stop, casc,
                  input  pulse, busy, cnt);
  modport slave  (input  ce, load, pre, div, oneshot, stop, casc,
                  output pulse, busy, cnt);
`else
  modport master (output ce, load, pre, div, oneshot, stop,
                  input  pulse, busy, cnt);
  modport slave  (input  ce, load, pre, div, oneshot, stop,
                  output pulse, busy, cnt);
`endif
endinterface

// File: rtl/j_pulse_gen.sv
// j_pulse_gen -- parametrised multi-channel prescaler/divider pulse generator.
// Each channel: prescaler down-counter feeding a divider down-counter; one
// sys_clk pulse per (pre+1)*(div+1) ticks, periodic or one-shot.
// Ports:
//   sys_clk  system clock (rising edge)
//   reset    synchronous, active-high
//   bus      j_pulse_gen_if.slave: ce, load, pre, div, oneshot, stop
//            (+ casc) in; pulse, busy, cnt out
// Optional: define J_PULSE_CASCADE_EN to let channel n>0 tick on the
// previous cycle's pulse of channel n-1 instead of ce (casc sampled on load).
module j_pulse_gen #(
  parameter int unsigned CH = 2,
  parameter int unsigned PW = 8,
  parameter int unsigned DW = 16
) (
  input  logic         sys_clk,
  input  logic         reset,
  j_pulse_gen_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        r_state    [CH];
  state_t        w_state_nx [CH];
  logic [PW-1:0] r_pre      [CH];
  logic [PW-1:0] r_pcnt     [CH];
  logic [PW-1:0] w_pcnt_nx  [CH];
  logic [DW-1:0] r_div      [CH];
  logic [DW-1:0] r_dcnt     [CH];
  logic [DW-1:0] w_dcnt_nx  [CH];
  logic [CH-1:0] r_mode;
  logic [CH-1:0] r_pulse;
  logic [CH-1:0] w_pulse_nx;
  logic [CH-1:0] w_tick;
`ifdef J_PULSE_CASCADE_EN
  logic [CH-1:0] r_casc;
`endif

  // Advance qualifier per channel
  always_comb begin
    w_tick = {CH{bus.ce}};
`ifdef J_PULSE_CASCADE_EN
    // r_pulse is last cycle's pulse; channel 0 has no predecessor
    for (int unsigned n = 1; n < CH; n++) begin
      if (r_casc[n]) w_tick[n] = r_pulse[n-1];
    end
`endif
  end

  // Next-state / counter logic
  always_comb begin
    for (int unsigned n = 0; n < CH; n++) begin
      w_state_nx[n] = r_state[n];
      w_pcnt_nx[n]  = r_pcnt[n];
      w_dcnt_nx[n]  = r_dcnt[n];
      w_pulse_nx[n] = 1'b0;
      if (bus.load[n]) begin
        // load wins over stop and over a coincident terminal count
        w_state_nx[n] = RUN;
        w_pcnt_nx[n]  = bus.pre;
        w_dcnt_nx[n]  = bus.div;
      end else if (r_state[n] == RUN && w_tick[n] && !bus.stop[n]) begin
        if (r_pcnt[n] != '0) begin
          w_pcnt_nx[n] = r_pcnt[n] - PW'(1);
        end else begin
          w_pcnt_nx[n] = r_pre[n];
          if (r_dcnt[n] != '0) begin
            w_dcnt_nx[n] = r_dcnt[n] - DW'(1);
          end else begin
            w_pulse_nx[n] = 1'b1;
            w_dcnt_nx[n]  = r_div[n];
            if (r_mode[n]) w_state_nx[n] = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < CH; n++) begin
        r_state[n] <= IDLE;
        r_pre[n]   <= '0;
        r_div[n]   <= '0;
        r_pcnt[n]  <= '0;
        r_dcnt[n]  <= '0;
      end
      r_mode  <= '0;
      r_pulse <= '0;
`ifdef J_PULSE_CASCADE_EN
      r_casc  <= '0;
`endif
    end else begin
      for (int unsigned n = 0; n < CH; n++) begin
        r_state[n] <= w_state_nx[n];
        r_pcnt[n]  <= w_pcnt_nx[n];
        r_dcnt[n]  <= w_dcnt_nx[n];
        if (bus.load[n]) begin
          r_pre[n]  <= bus.pre;
          r_div[n]  <= bus.div;
          r_mode[n] <= bus.oneshot;
`ifdef J_PULSE_CASCADE_EN
          r_casc[n] <= bus.casc[n];
`endif
        end
      end
      r_pulse <= w_pulse_nx;
    end
  end

  assign bus.pulse = r_pulse;

  always_comb begin
    bus.busy = '0;
    bus.cnt  = '0;
    for (int unsigned n = 0; n < CH; n++) begin
      bus.busy[n]          = (r_state[n] == RUN);
      bus.cnt[n*DW +: DW]  = r_dcnt[n];
    end
  end

endmodule

// File: tb/tb_j_pulse_gen.sv
// tb_j_pulse_gen -- directed self-checking bench for j_pulse_gen (CH=2, PW=8, DW=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_j_pulse_gen;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  j_pulse_gen_if #(.CH(2), .PW(8), .DW(16)) ifc ();

  j_pulse_gen #(.CH(2), .PW(8), .DW(16)) u_dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (ifc.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic applied;
    logic prev;

    rst = 1'b1;
    ifc.ce = 1'b0; ifc.load = '0; ifc.pre = '0; ifc.div = '0;
    ifc.oneshot = 1'b0; ifc.stop = '0;
`ifdef J_PULSE_CASCADE_EN
    ifc.casc = '0;
`endif
    cyc(2);
    check("reset pulse", ifc.pulse, 0);
    check("reset busy",  ifc.busy,  0);
    check("reset cnt",   ifc.cnt,   0);
    rst = 1'b0;

    // Periodic: pre=3, div=2 -> period 12
    ifc.ce = 1'b1; ifc.pre = 8'd3; ifc.div = 16'd2; ifc.oneshot = 1'b0; ifc.load = 2'b01;
    cyc(1);
    ifc.load = '0;
    check("periodic busy after load", ifc.busy[0], 1);
    check("periodic cnt after load",  ifc.cnt[15:0], 2);
    for (int i = 1; i <= 36; i++) begin
      cyc(1);
      check($sformatf("periodic pulse i=%0d", i), ifc.pulse[0], (i % 12 == 0));
      check($sformatf("periodic busy i=%0d", i),  ifc.busy[0], 1);
      if (i == 4)  check("periodic cnt i=4",  ifc.cnt[15:0], 1);
      if (i == 8)  check("periodic cnt i=8",  ifc.cnt[15:0], 0);
      if (i == 12) check("periodic cnt i=12", ifc.cnt[15:0], 2);
    end

    // Minimum period on channel 1, ce toggling
    rst = 1'b1; cyc(1); rst = 1'b0;
    ifc.ce = 1'b0; ifc.pre = '0; ifc.div = '0; ifc.load = 2'b10;
    cyc(1);
    ifc.load = '0;
    check("minper cnt1 after load", ifc.cnt[31:16], 0);
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ifc.ce = (i % 2 == 0);
      applied = ifc.ce;
      cyc(1);
      check($sformatf("minper pulse1 i=%0d", i), ifc.pulse[1], applied);
      check($sformatf("minper no b2b i=%0d", i), ifc.pulse[1] & prev, 0);
      check($sformatf("minper busy1 i=%0d", i), ifc.busy[1], 1);
      prev = ifc.pulse[1];
    end

    // One-shot: pre=1, div=1 -> single pulse after 4 ticks
    rst = 1'b1; cyc(1); rst = 1'b0;
    ifc.ce = 1'b1; ifc.pre = 8'd1; ifc.div = 16'd1; ifc.oneshot = 1'b1; ifc.load = 2'b01;
    cyc(1);
    ifc.load = '0; ifc.oneshot = 1'b0;
    for (int i = 1; i <= 54; i++) begin
      cyc(1);
      check($sformatf("oneshot pulse i=%0d", i), ifc.pulse[0], (i == 4));
      check($sformatf("oneshot busy i=%0d", i),  ifc.busy[0], (i < 4));
      if (i == 4) check("oneshot cnt reloaded", ifc.cnt[15:0], 1);
    end

    // Stop and resume: pre=4, div=0, stop over edges 3..9 -> pulse at 12 not 5
    rst = 1'b1; cyc(1); rst = 1'b0;
    ifc.ce = 1'b1; ifc.pre = 8'd4; ifc.div = 16'd0; ifc.load = 2'b01;
    cyc(1);
    ifc.load = '0;
    for (int i = 1; i <= 14; i++) begin
      ifc.stop = (i >= 3 && i <= 9) ? 2'b01 : 2'b00;
      cyc(1);
      check($sformatf("stop pulse i=%0d", i), ifc.pulse[0], (i == 12));
      check($sformatf("stop busy i=%0d", i),  ifc.busy[0], 1);
    end
    ifc.stop = '0;

    // Reload coincident with terminal count
    rst = 1'b1; cyc(1); rst = 1'b0;
    ifc.ce = 1'b1; ifc.pre = 8'd0; ifc.div = 16'd1; ifc.load = 2'b01;
    cyc(1);
    ifc.load = '0;
    cyc(1);
    check("reload pre-terminal cnt", ifc.cnt[15:0], 0);
    ifc.pre = 8'd2; ifc.div = 16'd5; ifc.load = 2'b01;
    cyc(1);
    ifc.load = '0;
    check("reload no pulse", ifc.pulse[0], 0);
    check("reload cnt",      ifc.cnt[15:0], 5);
    check("reload busy",     ifc.busy[0], 1);
    for (int i = 1; i <= 18; i++) begin
      cyc(1);
      check($sformatf("reload pulse i=%0d", i), ifc.pulse[0], (i == 18));
    end

    // Reset mid-run overrides a coincident load
    cyc(3);
    rst = 1'b1; ifc.load = 2'b01;
    cyc(1);
    check("midreset pulse", ifc.pulse, 0);
    check("midreset busy",  ifc.busy,  0);
    check("midreset cnt",   ifc.cnt,   0);
    rst = 1'b0; ifc.load = '0;
    cyc(5);
    check("idle busy",  ifc.busy,  0);
    check("idle pulse", ifc.pulse, 0);

`ifdef J_PULSE_CASCADE_EN
    // Cascade: ch1 (pre=0,div=2) ticks on ch0 pulses (pre=1,div=0)
    rst = 1'b1; cyc(1); rst = 1'b0;
    ifc.ce = 1'b0;
    ifc.pre = 8'd0; ifc.div = 16'd2; ifc.casc = 2'b10; ifc.load = 2'b10;
    cyc(1);
    ifc.pre = 8'd1; ifc.div = 16'd0; ifc.casc = 2'b00; ifc.load = 2'b01;
    cyc(1);
    ifc.load = '0; ifc.ce = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      cyc(1);
      check($sformatf("casc pulse0 i=%0d", i), ifc.pulse[0], (i % 2 == 0));
      check($sformatf("casc pulse1 i=%0d", i), ifc.pulse[1], (i >= 7 && (i - 7) % 6 == 0));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
